// File: rtl/image_pixel_normalizer_pkg.sv
// Shared constants and FSM encoding for the pixel normalizer and its per-channel lanes.
package image_pixel_normalizer_pkg;

    localparam int unsigned PIX_IN_W   = 8;
    localparam int unsigned PIX_OFFSET = 128;
    localparam int unsigned CENT_W     = PIX_IN_W + 1;
    localparam int unsigned SCALE_W    = 16;
    localparam int unsigned PROD_W     = CENT_W + SCALE_W;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StStream = 2'd1;
    localparam state_t StDrain  = 2'd2;
    localparam state_t StDone   = 2'd3;

endpackage

// File: rtl/image_pixel_normalizer_lane.sv
// One colour channel: re-centre around zero, scale, saturate; two register stages.
module pixel_norm_lane
    import image_pixel_normalizer_pkg::*;
#(
    parameter int unsigned               bitsize = 14,
    parameter logic signed [SCALE_W-1:0] Scale   = 16'sd128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld1_i,
    input  logic                  ld2_i,
    input  logic [PIX_IN_W-1:0]   pix_i,
    output logic signed [bitsize:0] pix_o
);

    localparam int SatMaxI = (1 << bitsize) - 1;
    localparam int SatMinI = -(1 << bitsize);
    localparam logic signed [PROD_W-1:0] SatMax = PROD_W'(SatMaxI);
    localparam logic signed [PROD_W-1:0] SatMin = PROD_W'(SatMinI);

    logic signed [CENT_W-1:0] centered_d, centered_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [bitsize:0]  sat_d, pix_q;

    always_comb begin
        centered_d = CENT_W'({1'b0, pix_i}) - CENT_W'(PIX_OFFSET);
        // Full-precision signed product; no rescaling of the fixed-point result.
        prod = centered_q * Scale;
        if (prod > SatMax) begin
            sat_d = SatMax[bitsize:0];
        end else if (prod < SatMin) begin
            sat_d = SatMin[bitsize:0];
        end else begin
            sat_d = prod[bitsize:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            centered_q <= '0;
            pix_q      <= '0;
        end else begin
            if (ld1_i) centered_q <= centered_d;
            if (ld2_i) pix_q <= sat_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/image_pixel_normalizer.sv
// Frame-oriented RGB normalizer: accepts one frame after start, streams scaled pixels to a FIFO.
module image_pixel_normalizer
    import image_pixel_normalizer_pkg::*;
#(
    parameter int unsigned               image_size = 224,
    parameter int unsigned               bitsize    = 14,
    parameter int unsigned               FRAC_BITS  = 7,
    parameter logic signed [SCALE_W-1:0] SCALE_R    = 16'sd128,
    parameter logic signed [SCALE_W-1:0] SCALE_G    = 16'sd128,
    parameter logic signed [SCALE_W-1:0] SCALE_B    = 16'sd128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [PIX_IN_W-1:0]     s_pixelR,
    input  logic [PIX_IN_W-1:0]     s_pixelG,
    input  logic [PIX_IN_W-1:0]     s_pixelB,
    input  logic                    hold,
    output logic signed [bitsize:0] output_pixelR,
    output logic signed [bitsize:0] output_pixelG,
    output logic signed [bitsize:0] output_pixelB,
    output logic                    wr_en,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned CntW = (image_size > 1) ? $clog2(image_size) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(image_size - 1);

    if (FRAC_BITS >= SCALE_W) begin : g_frac_check
        $error("FRAC_BITS must be narrower than the scale width");
    end

    state_t          state_q, state_d;
    logic [CntW-1:0] col_q, col_d, row_q, row_d;
    logic            v1_q, v2_q;
    logic            accept, last_pix, adv2;

    assign s_ready  = (state_q == StStream) && !hold;
    assign accept   = s_valid && s_ready;
    assign last_pix = accept && (col_q == LastIdx) && (row_q == LastIdx);
    assign adv2     = v1_q && !hold;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StStream;
            StStream: if (last_pix) state_d = StDrain;
            // Wait until the last accepted pixel has been written out.
            StDrain:  if (!v1_q && !v2_q) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (last_pix) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == LastIdx) begin
                col_d = '0;
                row_d = row_q + CntW'(1);
            end else begin
                col_d = col_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (!hold) begin
                v1_q <= accept;
                v2_q <= v1_q;
            end
        end
    end

    assign wr_en      = v2_q && !hold;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

    pixel_norm_lane #(.bitsize(bitsize), .Scale(SCALE_R)) u_lane_r (
        .clk_i (clk),
        .rst_i (rst),
        .ld1_i (accept),
        .ld2_i (adv2),
        .pix_i (s_pixelR),
        .pix_o (output_pixelR)
    );

    pixel_norm_lane #(.bitsize(bitsize), .Scale(SCALE_G)) u_lane_g (
        .clk_i (clk),
        .rst_i (rst),
        .ld1_i (accept),
        .ld2_i (adv2),
        .pix_i (s_pixelG),
        .pix_o (output_pixelG)
    );

    pixel_norm_lane #(.bitsize(bitsize), .Scale(SCALE_B)) u_lane_b (
        .clk_i (clk),
        .rst_i (rst),
        .ld1_i (accept),
        .ld2_i (adv2),
        .pix_i (s_pixelB),
        .pix_o (output_pixelB)
    );

endmodule
